synth_drv_5: RTL and testbench
==============================

SYNTH_DRV_5 -- requirements
Module: synth_drv_5

Interface
REQ-001 SHALL have parameter NUM_VEC, default 256, giving the number of vectors per run (legal range 1..65535).
REQ-002 SHALL have parameter SEED, default 32'hACE1_2024, giving the LFSR seed base; a zero-valued derived seed SHALL be replaced by 32'h1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE or DONE.
REQ-006 SHALL have ports out_a, out_b and out_c, output, 32 bits each: registered operand vectors to the core under test.
REQ-007 SHALL have port out_sel, output, 1 bit: registered select equal to vec_cnt[0] at issue.
REQ-008 SHALL have port dut_result, input, 32 bits: registered result returned by the core.
REQ-009 SHALL have ports busy and done, output, 1 bit each: busy high in RUN/DRAIN; done high in DONE.
REQ-010 SHALL have port pass, output, 1 bit: high in DONE iff err_cnt==0.
REQ-011 SHALL have ports err_cnt and vec_cnt, output, 16 bits each: mismatch count and vectors issued.
REQ-012 SHALL have ports first_err_idx (16 bits) and first_err_val (32 bits), outputs, per REQ-030.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN on start; DONE->RUN on start; start in RUN/DRAIN SHALL be ignored.
REQ-015 Entering RUN SHALL reload LFSR_a/b/c with SEED, SEED^32'h5555_5555 and SEED^32'hAAAA_AAAA, and clear err_cnt, vec_cnt and the first-error registers.
REQ-016 LFSRs SHALL be 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1), each advancing once per issued vector.
REQ-017 In RUN, one vector SHALL issue per cycle: out_a/b/c take the current LFSR values, and vec_cnt increments.
REQ-018 RUN->DRAIN SHALL occur on the edge issuing vector NUM_VEC-1; DRAIN SHALL last exactly 2 cycles, then enter DONE.
REQ-019 Expected value SHALL be exp = (b*c) + (b ^ (b*b*c)), all products and sums truncated to 32 bits, with b and c the issued out_b and out_c.
REQ-020 A vector issued at edge E SHALL be compared with dut_result at edge E+2, so the core has one register stage; a 2-deep expected/valid pipeline SHALL align the compare.
REQ-021 On mismatch err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-022 Comparisons SHALL occur only for issued vectors: none in IDLE/DONE, and exactly NUM_VEC per run including the DRAIN cycles.
REQ-023 Outside RUN, out_a/b/c/sel SHALL hold their last values.
REQ-024 done, pass, err_cnt and vec_cnt SHALL hold in DONE until the next start.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE and set out_a/b/c=0, out_sel=0, busy=0, done=0, pass=0, err_cnt=0, vec_cnt=0, first_err_idx=0, first_err_val=0, and the compare pipeline to invalid.
REQ-026 Reset during RUN/DRAIN SHALL abort the run with no further comparisons; the next start SHALL begin a fresh run.
REQ-027 Reset release SHALL take effect at the first clk rising edge with rst_n high.

Configuration
REQ-028 Macro SYNTH_DRV_FIRST_ERR_EN SHALL select first-error capture.
REQ-029 With the macro defined, the first mismatch of a run SHALL latch its vector index into first_err_idx and the observed dut_result into first_err_val; later mismatches SHALL not overwrite them.
REQ-030 Without the macro, first_err_idx and first_err_val SHALL be tied to 0, and no capture logic SHALL be present.

Verification
REQ-031 NUM_VEC=16, dut_result driven by a correct 1-stage reference core -> done after 16+2 cycles in RUN/DRAIN, err_cnt=0, pass=1, vec_cnt=16.
REQ-032 NUM_VEC=16, dut_result stuck at 32'h0 -> err_cnt=16, pass=0.
REQ-033 Correct core with only vector 5 corrupted (bit0 flipped), macro defined -> err_cnt=1, first_err_idx=5, first_err_val=exp5^1; macro undefined -> first_err_idx=0 and first_err_val=0.
REQ-034 start pulsed again at vector 3 of a run -> ignored, vec_cnt=16 at DONE; start in DONE -> counters cleared and an identical vector sequence repeated.
REQ-035 rst_n low at vector 7 -> all outputs 0 immediately (asynchronously), state IDLE, no comparisons counted after release until start.

Source files
------------

// File: rtl/synth_drv_5.sv
// Self-checking stimulus driver: issues LFSR operand vectors to a 1-stage core and scores its results.
// Optional first-error capture is enabled by defining SYNTH_DRV_FIRST_ERR_EN.
module synth_drv_5 #(
  parameter int unsigned NUM_VEC = 256,
  parameter logic [31:0] SEED    = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic        out_sel,
  input  logic [31:0] dut_result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [15:0] vec_cnt,
  output logic [15:0] first_err_idx,
  output logic [31:0] first_err_val
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] TAPS   = 32'h8020_0003;
  localparam logic [DW-1:0] RAW_A  = SEED;
  localparam logic [DW-1:0] RAW_B  = SEED ^ 32'h5555_5555;
  localparam logic [DW-1:0] RAW_C  = SEED ^ 32'hAAAA_AAAA;
  localparam logic [DW-1:0] SEED_A = (RAW_A == '0) ? 32'h1 : RAW_A;
  localparam logic [DW-1:0] SEED_B = (RAW_B == '0) ? 32'h1 : RAW_B;
  localparam logic [DW-1:0] SEED_C = (RAW_C == '0) ? 32'h1 : RAW_C;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VEC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  function automatic logic [DW-1:0] expect_fn(input logic [DW-1:0] b, input logic [DW-1:0] c);
    logic [DW-1:0] bc;
    logic [DW-1:0] bbc;
    bc  = b * c;
    bbc = b * bc;
    return bc + (b ^ bbc);
  endfunction

  state_e        state_q, state_d;
  logic          drain_q, drain_d;
  logic [DW-1:0] lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d, lfsr_c_q, lfsr_c_d;
  logic [DW-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
  logic          out_sel_q, out_sel_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CW-1:0] err_q, err_d, vec_q, vec_d;
  logic [1:0]    pv_q, pv_d;
  logic [DW-1:0] pe0_q, pe0_d, pe1_q, pe1_d;
  logic          issue, clear, mismatch;
`ifdef SYNTH_DRV_FIRST_ERR_EN
  logic [CW-1:0] pi0_q, pi0_d, pi1_q, pi1_d;
  logic [CW-1:0] fe_idx_q, fe_idx_d;
  logic [DW-1:0] fe_val_q, fe_val_d;
`endif

  // Next-state, issue and scoring logic
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    lfsr_a_d  = lfsr_a_q;
    lfsr_b_d  = lfsr_b_q;
    lfsr_c_d  = lfsr_c_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_c_d   = out_c_q;
    out_sel_d = out_sel_q;
    err_d     = err_q;
    vec_d     = vec_q;
    issue     = 1'b0;
    clear     = 1'b0;
`ifdef SYNTH_DRV_FIRST_ERR_EN
    fe_idx_d  = fe_idx_q;
    fe_val_d  = fe_val_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          clear   = 1'b1;
        end
      end
      S_RUN: begin
        issue   = 1'b1;
        drain_d = 1'b0;
        if (vec_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      out_a_d   = lfsr_a_q;
      out_b_d   = lfsr_b_q;
      out_c_d   = lfsr_c_q;
      out_sel_d = vec_q[0];
      lfsr_a_d  = lfsr_next(lfsr_a_q);
      lfsr_b_d  = lfsr_next(lfsr_b_q);
      lfsr_c_d  = lfsr_next(lfsr_c_q);
      vec_d     = vec_q + CW'(1);
    end

    // Two-deep alignment: issued at E, core registers at E+1, scored at E+2
    pv_d  = {pv_q[0], issue};
    pe0_d = expect_fn(lfsr_b_q, lfsr_c_q);
    pe1_d = pe0_q;
`ifdef SYNTH_DRV_FIRST_ERR_EN
    pi0_d = vec_q;
    pi1_d = pi0_q;
`endif

    mismatch = pv_q[1] && (dut_result != pe1_q);
    if (mismatch && (err_q != CNT_MAX)) err_d = err_q + CW'(1);
`ifdef SYNTH_DRV_FIRST_ERR_EN
    if (mismatch && (err_q == '0)) begin
      fe_idx_d = pi1_q;
      fe_val_d = dut_result;
    end
`endif

    if (clear) begin
      lfsr_a_d = SEED_A;
      lfsr_b_d = SEED_B;
      lfsr_c_d = SEED_C;
      err_d    = '0;
      vec_d    = '0;
`ifdef SYNTH_DRV_FIRST_ERR_EN
      fe_idx_d = '0;
      fe_val_d = '0;
`endif
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      drain_q   <= 1'b0;
      lfsr_a_q  <= SEED_A;
      lfsr_b_q  <= SEED_B;
      lfsr_c_q  <= SEED_C;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_c_q   <= '0;
      out_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      vec_q     <= '0;
      pv_q      <= '0;
      pe0_q     <= '0;
      pe1_q     <= '0;
`ifdef SYNTH_DRV_FIRST_ERR_EN
      pi0_q     <= '0;
      pi1_q     <= '0;
      fe_idx_q  <= '0;
      fe_val_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      lfsr_a_q  <= lfsr_a_d;
      lfsr_b_q  <= lfsr_b_d;
      lfsr_c_q  <= lfsr_c_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      out_c_q   <= out_c_d;
      out_sel_q <= out_sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      vec_q     <= vec_d;
      pv_q      <= pv_d;
      pe0_q     <= pe0_d;
      pe1_q     <= pe1_d;
`ifdef SYNTH_DRV_FIRST_ERR_EN
      pi0_q     <= pi0_d;
      pi1_q     <= pi1_d;
      fe_idx_q  <= fe_idx_d;
      fe_val_q  <= fe_val_d;
`endif
    end
  end

  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign out_c   = out_c_q;
  assign out_sel = out_sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_cnt = vec_q;
`ifdef SYNTH_DRV_FIRST_ERR_EN
  assign first_err_idx = fe_idx_q;
  assign first_err_val = fe_val_q;
`else
  assign first_err_idx = '0;
  assign first_err_val = '0;
`endif

endmodule

// File: tb/tb_synth_drv_5.sv
// Scoreboard bench for synth_drv_5: expected vectors and run results are queued at start,
// monitors compare whenever a vector issues or done rises.
module tb_synth_drv_5;
  localparam int unsigned NV   = 16;
  localparam logic [31:0] SEED = 32'hACE1_2024;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] out_a, out_b, out_c, dut_result, first_err_val;
  logic        out_sel, busy, done, pass;
  logic [15:0] err_cnt, vec_cnt, first_err_idx;

  typedef struct packed {
    logic [15:0] err;
    logic        pass;
    logic [15:0] vec;
    logic [15:0] fidx;
    logic [31:0] fval;
  } res_t;

  logic [96:0] vec_exp_q[$];
  res_t        res_exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          core_mode = 0;
  logic [31:0] bad_b, bad_c, exp5;
  logic [15:0] vprev = '0;
  logic        dprev = 1'b0;

  synth_drv_5 #(.NUM_VEC(NV), .SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_sel(out_sel),
    .dut_result(dut_result), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .vec_cnt(vec_cnt),
    .first_err_idx(first_err_idx), .first_err_val(first_err_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] c);
    logic [31:0] p, q;
    p = b * c;
    q = (b * b) * c;
    return p + (b ^ q);
  endfunction

  // Reference 1-stage core; mode 1 = stuck at zero, mode 2 = flip bit0 on vector 5
  always @(posedge clk) begin : core
    logic [31:0] r;
    r = model(out_b, out_c);
    if (core_mode == 2 && out_b == bad_b && out_c == bad_c) r = r ^ 32'h1;
    dut_result <= (core_mode == 1) ? 32'h0 : r;
  end

  // Monitors: a vector issue shows as a nonzero vec_cnt change, a run result as done rising
  always @(negedge clk) begin
    logic [96:0] ev;
    res_t er, ar;
    if (vec_cnt != vprev && vec_cnt != 16'h0) begin
      checks++;
      if (vec_exp_q.size() == 0) begin
        errors++;
        $display("FAIL vector: unexpected issue at vec_cnt=%0d", vec_cnt);
      end else begin
        ev = vec_exp_q.pop_front();
        if ({out_a, out_b, out_c, out_sel} !== ev) begin
          errors++;
          $display("FAIL vector%0d: got a=%h b=%h c=%h sel=%b want a=%h b=%h c=%h sel=%b",
                   vec_cnt - 16'd1, out_a, out_b, out_c, out_sel,
                   ev[96:65], ev[64:33], ev[32:1], ev[0]);
        end
      end
    end
    if (done && !dprev) begin
      checks++;
      ar = '{err: err_cnt, pass: pass, vec: vec_cnt, fidx: first_err_idx, fval: first_err_val};
      if (res_exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: done with no expected run");
      end else begin
        er = res_exp_q.pop_front();
        if (ar !== er) begin
          errors++;
          $display("FAIL result: got err=%0d pass=%b vec=%0d fidx=%0d fval=%h want err=%0d pass=%b vec=%0d fidx=%0d fval=%h",
                   ar.err, ar.pass, ar.vec, ar.fidx, ar.fval, er.err, er.pass, er.vec, er.fidx, er.fval);
        end
      end
    end
    vprev = vec_cnt;
    dprev = done;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_run(input logic [15:0] e_err, input logic e_pass,
                          input logic [15:0] e_fidx, input logic [31:0] e_fval);
    logic [31:0] a, b, c;
    a = SEED; b = SEED ^ 32'h5555_5555; c = SEED ^ 32'hAAAA_AAAA;
    for (int i = 0; i < int'(NV); i++) begin
      vec_exp_q.push_back({a, b, c, 1'(i & 1)});
      a = lfsr_step(a); b = lfsr_step(b); c = lfsr_step(c);
    end
`ifdef SYNTH_DRV_FIRST_ERR_EN
    res_exp_q.push_back('{err: e_err, pass: e_pass, vec: 16'(NV), fidx: e_fidx, fval: e_fval});
`else
    res_exp_q.push_back('{err: e_err, pass: e_pass, vec: 16'(NV), fidx: 16'h0, fval: 32'h0});
`endif
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Run to done; optionally re-pulse start at vector 3 (must be ignored)
  task automatic run_wait(input string name, input bit mid_start);
    int n;
    bit pulsed;
    pulsed = 0;
    pulse_start();
    n = 0;
    while (n < 200 && !done) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (mid_start && !pulsed && vec_cnt == 16'd3) begin
        start = 1'b1;
        pulsed = 1;
      end
    end
    start = 1'b0;
    check({name, "_latency"}, 128'(n), 128'(NV + 2));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] b, c;
    b = SEED ^ 32'h5555_5555; c = SEED ^ 32'hAAAA_AAAA;
    for (int i = 0; i < 5; i++) begin b = lfsr_step(b); c = lfsr_step(c); end
    bad_b = b; bad_c = c; exp5 = model(b, c);

    repeat (2) @(negedge clk);
    check("reset_outputs", 128'({out_a, out_b, out_c, out_sel, busy, done, pass, err_cnt, vec_cnt, first_err_idx, first_err_val}), 128'h0);
    #2 rst_n = 1'b1;

    core_mode = 0; push_run(16'd0, 1'b1, 16'd0, 32'h0);
    run_wait("run_good", 0);
    check("good_busy_low", 128'(busy), 128'h0);

    core_mode = 1; push_run(16'd16, 1'b0, 16'd0, 32'h0);
    run_wait("run_stuck", 0);

    core_mode = 2; push_run(16'd1, 1'b0, 16'd5, exp5 ^ 32'h1);
    run_wait("run_vec5", 0);

    repeat (3) @(negedge clk);
    check("done_hold", 128'({done, pass, err_cnt, vec_cnt}), 128'({1'b1, 1'b0, 16'd1, 16'(NV)}));

    core_mode = 0; push_run(16'd0, 1'b1, 16'd0, 32'h0);
    run_wait("run_restart", 1);

    // Reset mid-run with a stuck core: any compare after release would count an error
    core_mode = 1; push_run(16'd16, 1'b0, 16'd0, 32'h0);
    pulse_start();
    for (int n = 0; n < 50 && vec_cnt != 16'd7; n++) begin @(posedge clk); #1; end
    check("reached_vec7", 128'(vec_cnt), 128'd7);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 128'({out_a, out_b, out_c, out_sel, busy, done, pass, err_cnt, vec_cnt, first_err_idx, first_err_val}), 128'h0);
    vec_exp_q.delete();
    res_exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_idle", 128'({busy, done, pass, err_cnt, vec_cnt}), 128'h0);

    core_mode = 0; push_run(16'd0, 1'b1, 16'd0, 32'h0);
    run_wait("run_fresh", 0);

    repeat (2) @(negedge clk);
    check("vec_queue_drained", 128'(vec_exp_q.size()), 128'h0);
    check("res_queue_drained", 128'(res_exp_q.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end
endmodule
